// File: rtl/ife_pkg.sv
// ife_pkg: shared definitions for the IFE image-processing passes.
//   - default image geometry and pixel width
//   - threshold mode encodings (the 2-bit `sel` field)
//   - threshold-engine FSM state type
package ife_pkg;

  // Default geometry: 128x128 greyscale, 8-bit pixels.
  localparam int unsigned IFE_IMG_W = 128;
  localparam int unsigned IFE_IMG_H = 128;
  localparam int unsigned IFE_DW    = 8;
  localparam int unsigned IFE_AW    = $clog2(IFE_IMG_W * IFE_IMG_H);

  // Threshold modes.
  typedef enum logic [1:0] {
    MODE_BIN    = 2'd0,  // p > T ? MAX : 0
    MODE_INV    = 2'd1,  // p > T ? 0   : MAX
    MODE_TRUNC  = 2'd2,  // p > T ? T   : p
    MODE_TOZERO = 2'd3   // p > T ? p   : 0
  } mode_e;

  // Engine FSM. ST_MEAN is only reachable when the auto-threshold pass is built.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MEAN = 2'd1,
    ST_PROC = 2'd2,
    ST_DONE = 2'd3
  } state_e;

endpackage

// File: rtl/ife_thresh_op.sv
// ife_thresh_op: combinational threshold ALU, result = f(pixel, threshold, mode).
// All comparisons are unsigned and strict (pixel > threshold).
// Ports:
//   pix_i  [DW-1:0]  input pixel
//   thr_i  [DW-1:0]  threshold T
//   mode_i mode_e    threshold mode
//   res_c  [DW-1:0]  combinational result pixel
module ife_thresh_op
  import ife_pkg::*;
#(
  parameter int unsigned DW = IFE_DW
) (
  input  logic [DW-1:0] pix_i,
  input  logic [DW-1:0] thr_i,
  input  mode_e         mode_i,
  output logic [DW-1:0] res_c
);

  localparam logic [DW-1:0] PIX_MAX  = {DW{1'b1}};
  localparam logic [DW-1:0] PIX_ZERO = '0;

  logic above_c;

  // Mode select around a single shared comparator.
  always_comb begin
    res_c   = PIX_ZERO;
    above_c = (pix_i > thr_i);
    case (mode_i)
      MODE_BIN:    res_c = above_c ? PIX_MAX  : PIX_ZERO;
      MODE_INV:    res_c = above_c ? PIX_ZERO : PIX_MAX;
      MODE_TRUNC:  res_c = above_c ? thr_i    : pix_i;
      MODE_TOZERO: res_c = above_c ? pix_i    : PIX_ZERO;
      default:     res_c = PIX_ZERO;
    endcase
  end

endmodule

// File: rtl/ife_thresh_engine.sv
// ife_thresh_engine: streams an IMG_W x IMG_H greyscale image from the host
// image port and writes one thresholded pixel per input pixel to the layer-0
// result memory, in raster order, one pixel per cycle.
//
// Build option: define IFE_AUTO_THR_EN to add a MEAN pass ahead of PROC that
// sums the whole image and uses (sum >> AW) as the threshold instead of `thr`.
//
// Ports:
//   clk      rising-edge clock
//   reset    synchronous, active-high
//   ready    start request (sampled in IDLE only)
//   busy     high from start until the last result write
//   iaddr    image read address; idata valid by the following rising edge
//   idata    image pixel
//   sel      threshold mode, latched at start
//   thr      programmable threshold, latched at start
//   addr     result memory address
//   data_wr  result pixel
//   wen      result memory write enable
//   data_rd  result memory read data (reserved, unused)
module ife_thresh_engine
  import ife_pkg::*;
#(
  parameter int unsigned IMG_W = IFE_IMG_W,
  parameter int unsigned IMG_H = IFE_IMG_H,
  parameter int unsigned DW    = IFE_DW,
  parameter int unsigned AW    = $clog2(IMG_W * IMG_H)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ready,
  output logic          busy,
  output logic [AW-1:0] iaddr,
  input  logic [DW-1:0] idata,
  input  logic [1:0]    sel,
  input  logic [DW-1:0] thr,
  output logic [AW-1:0] addr,
  output logic [DW-1:0] data_wr,
  output logic          wen,
  input  logic [DW-1:0] data_rd
);

  localparam int unsigned   NPIX      = IMG_W * IMG_H;
  localparam logic [AW-1:0] LAST_ADDR = AW'(NPIX - 1);

  state_e        state_q, state_d;
  logic [AW-1:0] iaddr_q, iaddr_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] data_wr_q, data_wr_d;
  logic          wen_q, wen_d;
  logic          busy_q, busy_d;
  mode_e         mode_q, mode_d;
  logic [DW-1:0] thr_q, thr_d;
  logic          rd_done_q, rd_done_d;  // last pixel read; next PROC cycle is the final write
  logic [DW-1:0] op_res_c;

`ifdef IFE_AUTO_THR_EN
  localparam int unsigned SW = DW + AW;

  logic [SW-1:0] sum_q, sum_d;
  logic [SW-1:0] sum_next_c;
  logic [DW-1:0] unused_thr_c;

  // Programmed threshold is replaced by the image mean in this build.
  assign unused_thr_c = thr;
`endif

  logic unused_data_rd_c;
  assign unused_data_rd_c = ^data_rd;

  // Pixel ALU, driven by the latched mode/threshold so mid-run sel/thr changes are ignored.
  ife_thresh_op #(
    .DW (DW)
  ) u_op (
    .pix_i  (idata),
    .thr_i  (thr_q),
    .mode_i (mode_q),
    .res_c  (op_res_c)
  );

  // Next-state and next-output logic.
  always_comb begin
    state_d   = state_q;
    iaddr_d   = iaddr_q;
    addr_d    = addr_q;
    data_wr_d = data_wr_q;
    wen_d     = 1'b0;
    busy_d    = busy_q;
    mode_d    = mode_q;
    thr_d     = thr_q;
    rd_done_d = rd_done_q;
`ifdef IFE_AUTO_THR_EN
    sum_d      = sum_q;
    sum_next_c = sum_q + SW'(idata);
`endif

    case (state_q)
      ST_IDLE: begin
        iaddr_d = '0;
        busy_d  = 1'b0;
        if (ready) begin
          busy_d    = 1'b1;
          mode_d    = mode_e'(sel);
          rd_done_d = 1'b0;
`ifdef IFE_AUTO_THR_EN
          sum_d   = '0;
          state_d = ST_MEAN;
`else
          thr_d   = thr;
          state_d = ST_PROC;
`endif
        end
      end

`ifdef IFE_AUTO_THR_EN
      // Read-only sweep; the final pixel is folded in on the same edge the mean is taken.
      ST_MEAN: begin
        sum_d = sum_next_c;
        if (iaddr_q == LAST_ADDR) begin
          thr_d   = DW'(sum_next_c >> AW);
          iaddr_d = '0;
          state_d = ST_PROC;
        end else begin
          iaddr_d = iaddr_q + AW'(1);
        end
      end
`endif

      // Result for iaddr=k is registered at the end of cycle k and written in cycle k+1.
      ST_PROC: begin
        if (!rd_done_q) begin
          addr_d    = iaddr_q;
          data_wr_d = op_res_c;
          wen_d     = 1'b1;
          if (iaddr_q == LAST_ADDR) begin
            rd_done_d = 1'b1;  // hold iaddr at N-1, no wrap
          end else begin
            iaddr_d = iaddr_q + AW'(1);
          end
        end else begin
          busy_d  = 1'b0;
          state_d = ST_DONE;
        end
      end

      ST_DONE: begin
        iaddr_d = '0;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      iaddr_q   <= '0;
      addr_q    <= '0;
      data_wr_q <= '0;
      wen_q     <= 1'b0;
      busy_q    <= 1'b0;
      mode_q    <= MODE_BIN;
      thr_q     <= '0;
      rd_done_q <= 1'b0;
`ifdef IFE_AUTO_THR_EN
      sum_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      iaddr_q   <= iaddr_d;
      addr_q    <= addr_d;
      data_wr_q <= data_wr_d;
      wen_q     <= wen_d;
      busy_q    <= busy_d;
      mode_q    <= mode_d;
      thr_q     <= thr_d;
      rd_done_q <= rd_done_d;
`ifdef IFE_AUTO_THR_EN
      sum_q     <= sum_d;
`endif
    end
  end

  assign busy    = busy_q;
  assign iaddr   = iaddr_q;
  assign addr    = addr_q;
  assign data_wr = data_wr_q;
  assign wen     = wen_q;

endmodule

// File: tb/tb_ife_thresh_engine.sv
// Testbench for ife_thresh_engine on a reduced 32x16 image (N=512).
// Expected writes are queued at each run start and popped on every wen.
`timescale 1ns/1ps
module tb_ife_thresh_engine;

  localparam int unsigned TW  = 32;
  localparam int unsigned TH  = 16;
  localparam int unsigned TN  = TW * TH;
  localparam int unsigned TAW = 9;
  localparam int unsigned TDW = 8;
`ifdef IFE_AUTO_THR_EN
  localparam int unsigned EXP_BUSY  = 2 * TN + 1;
  localparam int unsigned MEAN_CYC  = TN;
  localparam int unsigned RST_LEFT  = TN;
`else
  localparam int unsigned EXP_BUSY  = TN + 1;
  localparam int unsigned MEAN_CYC  = 0;
  localparam int unsigned RST_LEFT  = TN - 500;
`endif

  logic            clk = 1'b0;
  logic            reset;
  logic            ready;
  logic            busy;
  logic [TAW-1:0]  iaddr;
  logic [TDW-1:0]  idata;
  logic [1:0]      sel;
  logic [TDW-1:0]  thr;
  logic [TAW-1:0]  addr;
  logic [TDW-1:0]  data_wr;
  logic            wen;
  logic [TDW-1:0]  data_rd;

  logic [TDW-1:0]        img [TN];
  logic [TAW+TDW-1:0]    exp_q [$];
  int                    n_assert = 0;
  int                    n_fail   = 0;

  always #5 clk = ~clk;

  assign idata   = img[iaddr];
  assign data_rd = '0;

  ife_thresh_engine #(
    .IMG_W (TW),
    .IMG_H (TH),
    .DW    (TDW),
    .AW    (TAW)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .ready   (ready),
    .busy    (busy),
    .iaddr   (iaddr),
    .idata   (idata),
    .sel     (sel),
    .thr     (thr),
    .addr    (addr),
    .data_wr (data_wr),
    .wen     (wen),
    .data_rd (data_rd)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] model(input logic [7:0] p, input logic [7:0] t, input logic [1:0] s);
    logic hi;
    hi = (p > t);
    case (s)
      2'd0:    return hi ? 8'hFF : 8'h00;
      2'd1:    return hi ? 8'h00 : 8'hFF;
      2'd2:    return hi ? t     : p;
      default: return hi ? p     : 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] mean_thr();
    int unsigned s;
    s = 0;
    for (int k = 0; k < TN; k++) s += img[k];
    return 8'(s >> TAW);
  endfunction

  // Scoreboard: each write must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (wen === 1'b1 && exp_q.size() > 0) begin
      logic [TAW+TDW-1:0] e;
      e = exp_q.pop_front();
      check("write", 32'({addr, data_wr}), 32'(e));
    end
  end

  // Queue expectations, pulse ready, confirm busy rises one cycle later.
  task automatic start_run(input logic [1:0] s, input logic [7:0] t);
    logic [7:0] te;
    te = t;
`ifdef IFE_AUTO_THR_EN
    te = mean_thr();
`endif
    for (int k = 0; k < TN; k++) exp_q.push_back({TAW'(k), model(img[k], te, s)});
    @(posedge clk); #1;
    ready = 1'b1;
    sel   = s;
    thr   = t;
    @(posedge clk); #1;
    ready = 1'b0;
    check("busy_rise", 32'(busy), 32'd1);
  endtask

  // Follow the run to completion under a cycle budget.
  task automatic finish_run(input bit toggle);
    int unsigned    cyc   = 0;
    int unsigned    wens  = 0;
    int unsigned    early = 0;
    logic [TAW-1:0] last_ia = '0;
    while (busy === 1'b1 && cyc < EXP_BUSY + 10) begin
      cyc++;
      if (wen === 1'b1) begin
        wens++;
        if (cyc <= MEAN_CYC) early++;
      end
      last_ia = iaddr;
      if (toggle) begin
        sel = 2'($urandom);
        thr = 8'($urandom);
      end
      @(posedge clk); #1;
    end
    check("busy_cycles", cyc, EXP_BUSY);
    check("wen_count", wens, TN);
    check("early_wen", early, 0);
    check("iaddr_hold", 32'(last_ia), TN - 1);
    check("sb_empty", exp_q.size(), 0);
    check("done_wen", 32'(wen), 0);
    exp_q.delete();
    @(posedge clk); #1;
    check("idle_iaddr", 32'(iaddr), 0);
    check("idle_busy", 32'(busy), 0);
  endtask

  initial begin
    reset = 1'b1;
    ready = 1'b0;
    sel   = 2'd0;
    thr   = 8'd0;
    for (int k = 0; k < TN; k++) img[k] = 8'(k % 256);
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy",    32'(busy),    0);
    check("rst_wen",     32'(wen),     0);
    check("rst_iaddr",   32'(iaddr),   0);
    check("rst_addr",    32'(addr),    0);
    check("rst_data_wr", 32'(data_wr), 0);
    reset = 1'b0;

    // Ramp image across modes and threshold boundaries.
    start_run(2'd0, 8'h7F); finish_run(1'b0);
    start_run(2'd2, 8'h40); finish_run(1'b0);
    start_run(2'd3, 8'h40); finish_run(1'b0);
    start_run(2'd1, 8'h40); finish_run(1'b0);
    start_run(2'd0, 8'hFF); finish_run(1'b0);
    start_run(2'd0, 8'h00); finish_run(1'b0);

    // Reset 500 cycles into the run.
    start_run(2'd0, 8'h7F);
    repeat (500) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    check("abort_busy",    32'(busy),    0);
    check("abort_wen",     32'(wen),     0);
    check("abort_iaddr",   32'(iaddr),   0);
    check("abort_addr",    32'(addr),    0);
    check("abort_data_wr", 32'(data_wr), 0);
    check("abort_left",    exp_q.size(), RST_LEFT);
    exp_q.delete();
    reset = 1'b0;
    @(posedge clk); #1;
    check("abort_no_wen", 32'(wen), 0);
    start_run(2'd0, 8'h7F); finish_run(1'b0);

    // Random image, sel/thr churning during the run.
    for (int k = 0; k < TN; k++) img[k] = 8'($urandom);
    start_run(2'd3, 8'h90); finish_run(1'b1);
    start_run(2'd2, 8'h55); finish_run(1'b1);

`ifdef IFE_AUTO_THR_EN
    // Half 0x20, half 0xA0: mean threshold 0x60.
    for (int k = 0; k < TN; k++) img[k] = (k < TN / 2) ? 8'h20 : 8'hA0;
    start_run(2'd0, 8'h11); finish_run(1'b0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
